sctr_pipe: RTL and testbench



---
 rtl/sctr_pipe.sv | 191 +++++++++++++++++++
 tb/tb_sctr_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sctr_pipe.sv
`timescale 1ns/1ps
// sctr_pipe: execute-stage to shared data bus controller with posted writes (up to MAX_WOS outstanding).
// Latency: write 2, read 3, divide 2 cycles minimum; command held under cmd_valid/cmd_ready until accepted.
// Bus watchdog abort is built only when SCTR_TIMEOUT_EN is defined; otherwise the FSM waits indefinitely.
module sctr_pipe #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int MAX_WOS = 4,
    parameter int TO_CYC  = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_en_i,
    input  logic            mem_we_i,
    input  logic [DW/8-1:0] mem_wem_i,
    input  logic [AW-1:0]   mem_addr_i,
    input  logic [DW-1:0]   mem_wdata_i,
    output logic [DW-1:0]   mem_rdata_o,
    input  logic            div_start_i,
    input  logic            div_ready_i,
    input  logic            iram_rstn_i,
    input  logic            trap_in_i,
    input  logic            trap_jump_i,
    input  logic            idex_mret_i,
    output logic            hx_valid_o,
    output logic            reg_we_o,
    output logic            csr_we_o,
    output logic            iram_rd_o,
    output logic            trap_stat_o,
    output logic [DW-1:0]   cmd_wdata,
    output logic [AW-1:0]   cmd_addr,
    output logic            cmd_we,
    output logic [DW/8-1:0] cmd_wem,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    input  logic [DW-1:0]   rsp_rdata,
    input  logic            rsp_valid,
    input  logic            rsp_error,
    output logic            rsp_ready,
    output logic            bus_err_o,
    output logic [AW-1:0]   bus_err_addr_o
);
    localparam int WCW = $clog2(MAX_WOS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;
    localparam logic [1:0] S_DIV  = 2'd3;

    if (DW % 8 != 0 || MAX_WOS < 1 || TO_CYC < 1) begin : g_param_chk
        $error("sctr_pipe: illegal parameter combination");
    end

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [WCW-1:0]  r_wcnt;
    logic            r_cmd_valid;
    logic            r_cmd_we;
    logic [DW/8-1:0] r_cmd_wem;
    logic [AW-1:0]   r_cmd_addr;
    logic [DW-1:0]   r_cmd_wdata;
    logic            r_trap_stat;
    logic            r_bus_err;
    logic [AW-1:0]   r_bus_err_addr;

    logic w_busy;
    logic w_launch;
    logic w_cmd_hs;
    logic w_rd_rsp;
    logic w_wr_rsp;
    logic w_spur_rsp;
    logic w_wr_acc;
    logic w_abort;
    logic w_done;
    logic w_hx;

    assign w_busy     = (r_state == S_CMD) || (r_state == S_RSP);
    // Reads wait for all posted writes to drain so read data cannot overtake a write.
    assign w_launch   = (r_state == S_IDLE) && !trap_in_i && !div_start_i && mem_en_i &&
                        (mem_we_i ? (r_wcnt < WCW'(MAX_WOS)) : (r_wcnt == '0));
    assign w_cmd_hs   = r_cmd_valid && cmd_ready;
    assign w_rd_rsp   = (r_state == S_RSP) && rsp_valid;
    assign w_wr_rsp   = (r_state != S_RSP) && rsp_valid && (r_wcnt != '0);
    assign w_spur_rsp = (r_state != S_RSP) && rsp_valid && (r_wcnt == '0);
    assign w_wr_acc   = w_cmd_hs && r_cmd_we;

`ifdef SCTR_TIMEOUT_EN
    localparam int WDW = $clog2(TO_CYC + 1);
    logic [WDW-1:0] r_wdog;

    // A completion in the limit cycle wins over the abort.
    assign w_abort = w_busy && (r_wdog >= WDW'(TO_CYC - 1)) && !(w_cmd_hs || w_rd_rsp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (w_busy && (w_state_nxt != S_IDLE)) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!trap_in_i && div_start_i) w_state_nxt = S_DIV;
                else if (w_launch)             w_state_nxt = S_CMD;
            end
            S_CMD: begin
                if (w_abort)        w_state_nxt = S_IDLE;
                else if (cmd_ready) w_state_nxt = r_cmd_we ? S_IDLE : S_RSP;
            end
            S_RSP: begin
                if (w_abort || rsp_valid) w_state_nxt = S_IDLE;
            end
            default: begin
                if (trap_in_i || div_ready_i) w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_done = 1'b0;
        case (r_state)
            S_CMD:   w_done = w_wr_acc || w_abort;
            S_RSP:   w_done = w_rd_rsp || w_abort;
            S_DIV:   w_done = div_ready_i;
            default: w_done = 1'b0;
        endcase
    end

    // A trap in flight lets the bus transaction finish but suppresses retirement.
    assign w_hx = (r_state == S_IDLE) ? !(div_start_i || iram_rstn_i || trap_in_i || mem_en_i)
                                      : (w_done && !trap_in_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_wcnt         <= '0;
            r_cmd_valid    <= 1'b0;
            r_cmd_we       <= 1'b0;
            r_cmd_wem      <= '0;
            r_cmd_addr     <= '0;
            r_cmd_wdata    <= '0;
            r_trap_stat    <= 1'b0;
            r_bus_err      <= 1'b0;
            r_bus_err_addr <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_launch) begin
                r_cmd_valid <= 1'b1;
                r_cmd_we    <= mem_we_i;
                r_cmd_wem   <= mem_wem_i;
                r_cmd_addr  <= mem_addr_i;
                r_cmd_wdata <= mem_wdata_i;
            end else if (w_cmd_hs || w_abort) begin
                r_cmd_valid <= 1'b0;
            end

            if (w_wr_acc && !w_wr_rsp)      r_wcnt <= r_wcnt + 1'b1;
            else if (!w_wr_acc && w_wr_rsp) r_wcnt <= r_wcnt - 1'b1;

            r_bus_err <= w_spur_rsp || ((w_wr_rsp || w_rd_rsp) && rsp_error) || w_abort;
            if ((w_rd_rsp && rsp_error) || w_abort) r_bus_err_addr <= r_cmd_addr;

            if (trap_jump_i)                                     r_trap_stat <= 1'b1;
            else if (r_trap_stat && idex_mret_i && w_hx)         r_trap_stat <= 1'b0;
        end
    end

    assign mem_rdata_o    = w_rd_rsp ? rsp_rdata : '0;
    assign hx_valid_o     = w_hx;
    assign reg_we_o       = w_hx;
    assign csr_we_o       = w_hx;
    assign iram_rd_o      = w_hx || trap_jump_i;
    assign trap_stat_o    = r_trap_stat;
    assign cmd_valid      = r_cmd_valid;
    assign cmd_we         = r_cmd_we;
    assign cmd_wem        = r_cmd_wem;
    assign cmd_addr       = r_cmd_addr;
    assign cmd_wdata      = r_cmd_wdata;
    assign rsp_ready      = 1'b1;
    assign bus_err_o      = r_bus_err;
    assign bus_err_addr_o = r_bus_err_addr;
endmodule

// File: tb/tb_sctr_pipe.sv
`timescale 1ns/1ps
// Bench for sctr_pipe: reset and combinational table, directed corner sequences, then a
// randomized read/write stream checked against a transaction-level model of the bus controller.
module tb_sctr_pipe;
    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int MAX_WOS = 4;
    localparam int TO_CYC  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_en_i, mem_we_i;
    logic [DW/8-1:0] mem_wem_i;
    logic [AW-1:0]   mem_addr_i;
    logic [DW-1:0]   mem_wdata_i;
    logic [DW-1:0]   mem_rdata_o;
    logic            div_start_i, div_ready_i, iram_rstn_i, trap_in_i, trap_jump_i, idex_mret_i;
    logic            hx_valid_o, reg_we_o, csr_we_o, iram_rd_o, trap_stat_o;
    logic [DW-1:0]   cmd_wdata;
    logic [AW-1:0]   cmd_addr;
    logic            cmd_we;
    logic [DW/8-1:0] cmd_wem;
    logic            cmd_valid, cmd_ready;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_valid, rsp_error, rsp_ready;
    logic            bus_err_o;
    logic [AW-1:0]   bus_err_addr_o;

    always #5 clk = ~clk;

    sctr_pipe #(.DW(DW), .AW(AW), .MAX_WOS(MAX_WOS), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .mem_en_i(mem_en_i), .mem_we_i(mem_we_i), .mem_wem_i(mem_wem_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
        .div_start_i(div_start_i), .div_ready_i(div_ready_i), .iram_rstn_i(iram_rstn_i),
        .trap_in_i(trap_in_i), .trap_jump_i(trap_jump_i), .idex_mret_i(idex_mret_i),
        .hx_valid_o(hx_valid_o), .reg_we_o(reg_we_o), .csr_we_o(csr_we_o),
        .iram_rd_o(iram_rd_o), .trap_stat_o(trap_stat_o),
        .cmd_wdata(cmd_wdata), .cmd_addr(cmd_addr), .cmd_we(cmd_we), .cmd_wem(cmd_wem),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_rdata(rsp_rdata), .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_ready(rsp_ready),
        .bus_err_o(bus_err_o), .bus_err_addr_o(bus_err_addr_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr_in();
        mem_en_i = 0; mem_we_i = 0; mem_wem_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
        div_start_i = 0; div_ready_i = 0; iram_rstn_i = 0; trap_in_i = 0; trap_jump_i = 0;
        idex_mret_i = 0; cmd_ready = 0; rsp_rdata = '0; rsp_valid = 0; rsp_error = 0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_en_i = 1; mem_we_i = 1; mem_addr_i = a; mem_wdata_i = d; mem_wem_i = '1; cmd_ready = 1;
        smp; chk("wr_idle", {hx_valid_o, cmd_valid}, 2'b00); step;
        smp; chk("wr_accept", {hx_valid_o, cmd_valid}, 2'b11);
        chk("wr_cmd", {cmd_addr, cmd_wdata}, {a, d}); step;
        mem_en_i = 0; cmd_ready = 0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic err);
        mem_en_i = 1; mem_we_i = 0; mem_addr_i = a; cmd_ready = 1;
        smp; chk("rd_idle", {hx_valid_o, cmd_valid}, 2'b00); step;
        smp; chk("rd_cmd", {hx_valid_o, cmd_valid, cmd_we, cmd_addr}, {1'b0, 1'b1, 1'b0, a}); step;
        rsp_valid = 1; rsp_rdata = d; rsp_error = err;
        smp; chk("rd_rsp", {hx_valid_o, mem_rdata_o}, {1'b1, d}); step;
        rsp_valid = 0; rsp_error = 0; mem_en_i = 0; cmd_ready = 0;
    endtask

    typedef struct {
        logic mem_en, div_start, iram_rstn, trap_in, trap_jump;
        logic exp_hx, exp_iram_rd;
    } vec_t;

    initial begin
        vec_t tbl[9];
        int   out;
        int   st;
        logic            rq_we;
        logic [AW-1:0]   rq_addr;
        logic [DW-1:0]   rq_wdata;
        logic [DW/8-1:0] rq_wem;

        tbl[0] = '{0, 0, 0, 0, 0, 1, 1};
        tbl[1] = '{1, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 1, 0, 0, 0, 0};
        tbl[4] = '{0, 0, 0, 1, 0, 0, 0};
        tbl[5] = '{0, 0, 0, 0, 1, 1, 1};
        tbl[6] = '{0, 0, 0, 1, 1, 0, 1};
        tbl[7] = '{1, 0, 1, 0, 1, 0, 1};
        tbl[8] = '{0, 0, 1, 1, 0, 0, 0};

        clr_in();
        rst = 1;
        step; step;
        rst = 0;
        smp;
        chk("rst_hx", {hx_valid_o, reg_we_o, csr_we_o, iram_rd_o}, 4'hF);
        chk("rst_cmd", {cmd_valid, cmd_we, cmd_wem, cmd_addr}, 0);
        chk("rst_wdata", cmd_wdata, 0);
        chk("rst_misc", {trap_stat_o, bus_err_o, rsp_ready, mem_rdata_o}, {1'b0, 1'b0, 1'b1, 32'h0});
        chk("rst_eaddr", bus_err_addr_o, 0);
        step;

        // IDLE-state retirement and fetch-enable rules, each from a fresh reset
        for (int i = 0; i < 9; i++) begin
            clr_in(); rst = 1; step; rst = 0;
            mem_en_i = tbl[i].mem_en; mem_we_i = 1; div_start_i = tbl[i].div_start;
            iram_rstn_i = tbl[i].iram_rstn; trap_in_i = tbl[i].trap_in; trap_jump_i = tbl[i].trap_jump;
            smp;
            chk($sformatf("tbl%0d", i), {hx_valid_o, reg_we_o, csr_we_o, iram_rd_o, cmd_valid},
                {tbl[i].exp_hx, tbl[i].exp_hx, tbl[i].exp_hx, tbl[i].exp_iram_rd, 1'b0});
            step;
        end
        clr_in(); rst = 1; step; rst = 0;

        do_read(32'h100, 32'hDEADBEEF, 1'b0);

        // five posted writes against a limit of four
        for (int i = 0; i < 4; i++) do_write(32'h3000 + 32'(4 * i), $urandom);
        mem_en_i = 1; mem_we_i = 1; mem_addr_i = 32'h3010; mem_wdata_i = 32'h55AA55AA; cmd_ready = 1;
        for (int i = 0; i < 5; i++) begin
            smp; chk("w5_stall", {hx_valid_o, cmd_valid}, 2'b00); step;
        end
        rsp_valid = 1;
        smp; chk("w5_rsp", {hx_valid_o, cmd_valid}, 2'b00); step;
        rsp_valid = 0;
        smp; chk("w5_cap", {hx_valid_o, cmd_valid}, 2'b00); step;
        smp; chk("w5_accept", {hx_valid_o, cmd_valid, cmd_addr}, {2'b11, 32'h3010}); step;
        mem_en_i = 0; cmd_ready = 0;
        // four counted responses, then the fifth is spurious
        for (int i = 0; i < 5; i++) begin
            rsp_valid = 1; step; rsp_valid = 0;
            smp; chk("w5_drain_err", bus_err_o, (i == 4)); step;
        end
        smp; chk("spur_once", bus_err_o, 0); step;

        // read blocked behind two outstanding writes
        do_write(32'h4000, 32'h11111111);
        do_write(32'h4004, 32'h22222222);
        mem_en_i = 1; mem_we_i = 0; mem_addr_i = 32'h4100; cmd_ready = 1;
        for (int i = 0; i < 3; i++) begin
            smp; chk("rd_wait", cmd_valid, 0); step;
        end
        rsp_valid = 1; smp; chk("rd_wait_r1", cmd_valid, 0); step;
        rsp_valid = 0; smp; chk("rd_wait_g", cmd_valid, 0); step;
        rsp_valid = 1; smp; chk("rd_wait_r2", cmd_valid, 0); step;
        rsp_valid = 0; smp; chk("rd_cap", cmd_valid, 0); step;
        smp; chk("rd_go", {cmd_valid, cmd_addr}, {1'b1, 32'h4100}); step;
        rsp_valid = 1; rsp_rdata = 32'h12345678;
        smp; chk("rd_go_rsp", {hx_valid_o, mem_rdata_o}, {1'b1, 32'h12345678}); step;
        clr_in();
        smp; chk("rd_go_berr", bus_err_o, 0); step;

        // read error
        do_read(32'h2004, 32'hCAFEF00D, 1'b1);
        smp; chk("err_pulse", {bus_err_o, bus_err_addr_o}, {1'b1, 32'h2004}); step;
        smp; chk("err_once", bus_err_o, 0); step;

        // reset mid-transaction drops cmd_valid and clears captured error address
        mem_en_i = 1; mem_we_i = 1; mem_addr_i = 32'h7000; cmd_ready = 0;
        step;
        smp; chk("mid_cv", cmd_valid, 1); step;
        rst = 1; mem_en_i = 0; step; rst = 0;
        smp; chk("mid_rst", {cmd_valid, bus_err_addr_o}, 0); step;

        // trap during RSP, then trap entry and mret
        mem_en_i = 1; mem_we_i = 0; mem_addr_i = 32'h500; cmd_ready = 1;
        step; step;
        trap_in_i = 1;
        smp; chk("trap_rsp_wait", hx_valid_o, 0); step;
        rsp_valid = 1; rsp_rdata = 32'hA5A5A5A5;
        smp; chk("trap_rsp", {hx_valid_o, mem_rdata_o}, {1'b0, 32'hA5A5A5A5}); step;
        rsp_valid = 0; mem_en_i = 0; cmd_ready = 0; trap_jump_i = 1;
        smp; chk("trap_jump", {hx_valid_o, iram_rd_o, cmd_valid, trap_stat_o}, 4'b0100); step;
        trap_jump_i = 0; trap_in_i = 0; idex_mret_i = 1;
        smp; chk("trap_set", {trap_stat_o, hx_valid_o}, 2'b11); step;
        idex_mret_i = 0;
        smp; chk("trap_clr", trap_stat_o, 0); step;
        trap_jump_i = 1; idex_mret_i = 1; step;
        smp; chk("trap_jmp_set", trap_stat_o, 1); step;
        smp; chk("trap_jmp_wins", trap_stat_o, 1); step;
        trap_jump_i = 0; step;
        idex_mret_i = 0;
        smp; chk("trap_mret", trap_stat_o, 0); step;

        // divide, then divide interrupted by trap
        div_start_i = 1;
        smp; chk("div_start", hx_valid_o, 0); step;
        div_start_i = 0; div_ready_i = 1;
        smp; chk("div_done", hx_valid_o, 1); step;
        div_ready_i = 0;
        smp; chk("div_idle", hx_valid_o, 1); step;
        div_start_i = 1; step;
        div_start_i = 0; trap_in_i = 1;
        smp; chk("div_trap", hx_valid_o, 0); step;
        trap_in_i = 0;
        smp; chk("div_trap_idle", hx_valid_o, 1); step;

        // stalled command: held indefinitely, or aborted by the watchdog
        mem_en_i = 1; mem_we_i = 1; mem_addr_i = 32'h6000; mem_wdata_i = 32'h0BADF00D; cmd_ready = 0;
        step;
        for (int i = 1; i <= TO_CYC; i++) begin
            smp;
`ifdef SCTR_TIMEOUT_EN
            chk("wdog_cmd", {hx_valid_o, cmd_valid, mem_rdata_o}, {(i == TO_CYC), 1'b1, 32'h0});
`else
            chk("hold_cmd", {hx_valid_o, cmd_valid}, 2'b01);
`endif
            step;
        end
`ifdef SCTR_TIMEOUT_EN
        mem_en_i = 0;
        smp; chk("wdog_err", {bus_err_o, cmd_valid, bus_err_addr_o}, {2'b10, 32'h6000}); step;
        do_read(32'h6100, 32'h77777777, 1'b0);
`else
        cmd_ready = 1;
        smp; chk("hold_accept", {hx_valid_o, cmd_valid}, 2'b11); step;
        mem_en_i = 0; cmd_ready = 0; rsp_valid = 1; step;
        rsp_valid = 0;
        smp; chk("hold_rsp", bus_err_o, 0); step;
`endif
        clr_in();

        // randomized traffic against a transaction-level model
        out = 0;
        st  = 0;
        rq_we = 0; rq_addr = '0; rq_wdata = '0; rq_wem = '0;
        for (int c = 0; c < 3000; c++) begin
            logic exp_cv, hs, done_w, done_r, exp_hx, wresp;
            if (st == 0 && $urandom_range(5) != 0) begin
                rq_we = 1'($urandom_range(1)); rq_addr = $urandom; rq_wdata = $urandom;
                rq_wem = 4'($urandom_range(15));
                st = 1;
            end
            mem_en_i = (st != 0); mem_we_i = rq_we; mem_addr_i = rq_addr;
            mem_wdata_i = rq_wdata; mem_wem_i = rq_wem;
            cmd_ready = ($urandom_range(2) != 0);
            rsp_rdata = $urandom;
            if (st == 3)      rsp_valid = 1'($urandom_range(1));
            else if (out > 0) rsp_valid = ($urandom_range(2) == 0);
            else              rsp_valid = 0;

            exp_cv = (st == 2);
            hs     = exp_cv && cmd_ready;
            done_w = hs && rq_we;
            done_r = (st == 3) && rsp_valid;
            exp_hx = (st == 0) || done_w || done_r;
            wresp  = rsp_valid && (st != 3);

            smp;
            chk("rnd_hx", hx_valid_o, exp_hx);
            chk("rnd_cv", cmd_valid, exp_cv);
            if (exp_cv) begin
                chk("rnd_cmd_a", {cmd_we, cmd_addr}, {rq_we, rq_addr});
                chk("rnd_cmd_d", {cmd_wem, cmd_wdata}, {rq_wem, rq_wdata});
            end
            if (done_r) chk("rnd_rdata", mem_rdata_o, rsp_rdata);
            chk("rnd_berr", bus_err_o, 0);

            case (st)
                1: if (rq_we ? (out < MAX_WOS) : (out == 0)) st = 2;
                2: if (hs) begin
                       if (rq_we) begin out++; st = 0; end
                       else st = 3;
                   end
                3: if (rsp_valid) st = 0;
                default: ;
            endcase
            if (wresp) out--;
            step;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
